// File: rtl/fetch_align_pkg.sv
// Shared wires package for the fetch/align front end.
//
// Holds the FSM state enum, the bundled input/output record types used by
// fetch_align, the halfword queue depth and a small helper that classifies
// a halfword as the start of a compressed (16-bit) or a full 32-bit
// instruction.
package fetch_align_pkg;

    // Request FSM: IDLE (queue too full to fetch), FETCH (request on the bus),
    // KILL (a redirect arrived while a request was still unaccepted; the bus
    // request is held until accepted and its data thrown away).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        KILL  = 2'd2
    } fetch_align_state_type;

    typedef struct packed {
        logic        fetch_ready;
        logic [31:0] fetch_rdata;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        instr_ready;
    } fetch_align_in_type;

    typedef struct packed {
        logic        fetch_valid;
        logic [31:0] fetch_addr;
        logic        instr_valid;
        logic [31:0] instr;
        logic [31:0] instr_pc;
        logic        instr_rvc;
    } fetch_align_out_type;

    // Halfword queue depth: one fetched word plus one pending word.
    localparam int unsigned QUEUE_DEPTH = 4;

    // A halfword whose two low bits are not 2'b11 starts a 16-bit instruction.
    function automatic logic is_rvc(input logic [15:0] half);
        return half[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Four-entry halfword FIFO sitting between the instruction memory and the
// aligner.
//
// Ports:
//   clock, reset      : clock and asynchronous active-high reset
//   flush             : empty the queue (takes priority over push/pop)
//   push              : number of halfwords written this cycle (0/1/2)
//   push_lo, push_hi  : first and second halfword to write (push_lo first)
//   pop               : number of halfwords removed from the head (0/1/2)
//   count             : halfwords currently held (0..4)
//   h0, h1            : head entry and the entry behind it
//
// Push and pop happen in the same cycle; the caller guarantees the
// occupancy never exceeds four.
module fetch_queue
    import fetch_align_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [1:0]  push,
    input  logic [15:0] push_lo,
    input  logic [15:0] push_hi,
    input  logic [1:0]  pop,
    output logic [2:0]  count,
    output logic [15:0] h0,
    output logic [15:0] h1
);

    logic [15:0]            slot_reg [QUEUE_DEPTH];
    logic [1:0]             rd_ptr_reg;
    logic [1:0]             wr_ptr_reg;
    logic [2:0]             count_reg;
    logic [1:0]             rd_ptr_inc;
    logic [1:0]             wr_ptr_inc;
    logic [QUEUE_DEPTH-1:0] we_lo;
    logic [QUEUE_DEPTH-1:0] we_hi;

    assign rd_ptr_inc = rd_ptr_reg + 2'd1;
    assign wr_ptr_inc = wr_ptr_reg + 2'd1;

    // Per-slot write enables: the first pushed halfword lands at the write
    // pointer, the second one in the slot after it.
    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_we
            assign we_lo[gi] = !flush && (push != 2'd0) && (wr_ptr_reg == 2'(gi));
            assign we_hi[gi] = !flush && (push == 2'd2) && (wr_ptr_inc == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= 2'd0;
            wr_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else if (flush) begin
            rd_ptr_reg <= 2'd0;
            wr_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else begin
            rd_ptr_reg <= rd_ptr_reg + pop;
            wr_ptr_reg <= wr_ptr_reg + push;
            count_reg  <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                slot_reg[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (we_lo[i]) begin
                    slot_reg[i] <= push_lo;
                end else if (we_hi[i]) begin
                    slot_reg[i] <= push_hi;
                end
            end
        end
    end

    assign count = count_reg;
    assign h0    = slot_reg[rd_ptr_reg];
    assign h1    = slot_reg[rd_ptr_inc];

endmodule

// File: rtl/fetch_align.sv
// Instruction fetch and alignment unit for a mixed 16/32-bit instruction
// stream.
//
// Fetches aligned 32-bit words from instruction memory, buffers them as
// halfwords and presents one complete (possibly word-straddling)
// instruction per handshake to the decode stage. Supports redirects
// (branch/jump/trap) at any time, including while a memory request is
// still waiting to be accepted.
//
// Ports:
//   clock, reset             : clock, asynchronous active-high reset
//   fetch_valid/fetch_addr   : memory request strobe and word address
//   fetch_ready/fetch_rdata  : memory accept; data valid in the same cycle
//   redirect/redirect_pc     : flush and restart at redirect_pc (bit 0 ignored)
//   instr_valid/instr_ready  : downstream handshake
//   instr, instr_pc          : aligned instruction and its halfword address
//   instr_rvc                : presented instruction is 16-bit
module fetch_align
    import fetch_align_pkg::*;
#(
    parameter logic [31:0] reset_pc = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        fetch_valid,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ready,
    input  logic [31:0] fetch_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_rvc
);

    fetch_align_state_type state_reg, state_next;
    logic [31:0] fetch_addr_reg, fetch_addr_next;
    logic [31:0] instr_pc_reg, instr_pc_next;
    logic [31:0] target_reg, target_next;
    logic        drop_low_reg, drop_low_next;

    fetch_align_in_type  in_s;
    fetch_align_out_type out_s;

    logic [2:0]  count;
    logic [15:0] h0;
    logic [15:0] h1;
    logic [1:0]  push_n;
    logic [1:0]  pop_n;
    logic        flush;
    logic [15:0] push_lo;
    logic [15:0] push_hi;
    logic        h0_rvc;
    logic        can_issue;
    logic [2:0]  count_after_pop;
    logic [31:0] redirect_word;
    logic        unused_pc_bit;

    assign in_s = '{
        fetch_ready: fetch_ready,
        fetch_rdata: fetch_rdata,
        redirect:    redirect,
        redirect_pc: redirect_pc,
        instr_ready: instr_ready
    };

    // Bit 0 of a redirect target carries no information for halfword
    // aligned code.
    assign unused_pc_bit = in_s.redirect_pc[0];

    fetch_queue u_queue (
        .clock   (clock),
        .reset   (reset),
        .flush   (flush),
        .push    (push_n),
        .push_lo (push_lo),
        .push_hi (push_hi),
        .pop     (pop_n),
        .count   (count),
        .h0      (h0),
        .h1      (h1)
    );

    // When the low halfword of the first word after an odd-halfword redirect
    // must be skipped, only the upper halfword enters the queue.
    assign push_lo = drop_low_reg ? in_s.fetch_rdata[31:16] : in_s.fetch_rdata[15:0];
    assign push_hi = in_s.fetch_rdata[31:16];

    always_comb begin
        state_next      = state_reg;
        fetch_addr_next = fetch_addr_reg;
        instr_pc_next   = instr_pc_reg;
        target_next     = target_reg;
        drop_low_next   = drop_low_reg;
        push_n          = 2'd0;
        pop_n           = 2'd0;
        flush           = 1'b0;
        out_s           = '0;

        redirect_word = {in_s.redirect_pc[31:2], 2'b00};
        h0_rvc        = is_rvc(h0);
        can_issue     = (count >= 3'd2) || ((count != 3'd0) && h0_rvc);

        // Output side: a redirect cycle never presents an instruction.
        out_s.instr_valid = can_issue && !in_s.redirect;
        out_s.instr_rvc   = out_s.instr_valid && h0_rvc;
        if (out_s.instr_valid) begin
            out_s.instr = h0_rvc ? {16'h0000, h0} : {h1, h0};
        end
        out_s.instr_pc    = instr_pc_reg;
        out_s.fetch_valid = (state_reg == FETCH) || (state_reg == KILL);
        out_s.fetch_addr  = fetch_addr_reg;

        if (out_s.instr_valid && in_s.instr_ready) begin
            pop_n         = h0_rvc ? 2'd1 : 2'd2;
            instr_pc_next = instr_pc_reg + (h0_rvc ? 32'd2 : 32'd4);
        end
        count_after_pop = count - {1'b0, pop_n};

        if (in_s.redirect) begin
            flush         = 1'b1;
            instr_pc_next = {in_s.redirect_pc[31:1], 1'b0};
            drop_low_next = in_s.redirect_pc[1];
            target_next   = redirect_word;
            if ((state_reg != IDLE) && !in_s.fetch_ready) begin
                // The bus request cannot be withdrawn: keep it, remember
                // the target and throw the response away when it comes.
                state_next = KILL;
            end else begin
                // No request in flight (or it completes now and its data
                // is dropped): restart immediately at the target.
                fetch_addr_next = redirect_word;
                state_next      = FETCH;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (count_after_pop <= 3'd2) begin
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    if (in_s.fetch_ready) begin
                        push_n          = drop_low_reg ? 2'd1 : 2'd2;
                        drop_low_next   = 1'b0;
                        fetch_addr_next = fetch_addr_reg + 32'd4;
                        // Keep fetching only while the next word still fits.
                        if ((count_after_pop + {1'b0, push_n}) <= 3'd2) begin
                            state_next = FETCH;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                KILL: begin
                    if (in_s.fetch_ready) begin
                        fetch_addr_next = target_reg;
                        state_next      = FETCH;
                    end
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= FETCH;
            fetch_addr_reg <= {reset_pc[31:2], 2'b00};
            instr_pc_reg   <= {reset_pc[31:1], 1'b0};
            target_reg     <= {reset_pc[31:2], 2'b00};
            drop_low_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fetch_addr_reg <= fetch_addr_next;
            instr_pc_reg   <= instr_pc_next;
            target_reg     <= target_next;
            drop_low_reg   <= drop_low_next;
        end
    end

    assign fetch_valid = out_s.fetch_valid;
    assign fetch_addr  = out_s.fetch_addr;
    assign instr_valid = out_s.instr_valid;
    assign instr       = out_s.instr;
    assign instr_pc    = out_s.instr_pc;
    assign instr_rvc   = out_s.instr_rvc;

endmodule

// File: tb/tb_fetch_align.sv
// Self-checking bench for fetch_align: a word-addressed memory model answers
// requests, and a halfword-stream reference model predicts every consumed
// instruction from the memory contents and the current program counter.
module tb_fetch_align;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int M_ZERO = 0;
    localparam int M_ONE  = 1;
    localparam int M_RAND = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        fetch_ready = 1'b0;
    logic [31:0] fetch_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_rvc;

    always #5 clock = ~clock;

    fetch_align #(.reset_pc(RESET_PC)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_rdata (fetch_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_rvc   (instr_rvc)
    );

    logic [31:0] mem [256];

    int          n_checks = 0;
    int          n_errors = 0;
    int          consumed = 0;
    logic [31:0] model_pc;
    logic [31:0] last_instr;
    logic [31:0] last_pc;
    logic        last_rvc;
    logic        pending = 1'b0;
    logic [31:0] prev_addr;
    logic        obs_fvalid;
    logic [31:0] obs_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference view of memory as a halfword stream (1 KB image, wraps).
    function automatic logic [15:0] half_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic fill_random(input logic only_16);
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = $urandom;
            if (only_16) begin
                if (w[1:0] == 2'b11)   w[1:0]   = 2'b01;
                if (w[17:16] == 2'b11) w[17:16] = 2'b10;
            end
            mem[i] = w;
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit later.
    task automatic step(input int rdy_mode, input int irdy_mode,
                        input logic do_redir, input logic [31:0] rpc);
        logic        want;
        logic [15:0] e0;
        logic [31:0] e_instr;
        logic        e_rvc;
        @(negedge clock);
        case (rdy_mode)
            M_ZERO:  want = 1'b0;
            M_ONE:   want = 1'b1;
            default: want = ($urandom_range(0, 99) < 60);
        endcase
        fetch_ready = want && fetch_valid;
        fetch_rdata = fetch_ready ? mem[fetch_addr[9:2]] : $urandom;
        case (irdy_mode)
            M_ZERO:  instr_ready = 1'b0;
            M_ONE:   instr_ready = 1'b1;
            default: instr_ready = ($urandom_range(0, 99) < 70);
        endcase
        redirect    = do_redir;
        redirect_pc = rpc;
        #1;
        obs_fvalid = fetch_valid;
        obs_addr   = fetch_addr;
        check_eq("addr_align", {30'h0, fetch_addr[1:0]}, 32'h0);
        if (pending) check_eq("addr_hold", fetch_addr, prev_addr);
        if (do_redir) check_eq("valid_on_redirect", {31'h0, instr_valid}, 32'h0);
        if (instr_valid && instr_ready) begin
            e0 = half_at(model_pc);
            // Low bits 2'b11 mark a 32-bit encoding that continues into
            // the next halfword.
            e_rvc   = (e0[1:0] != 2'b11);
            e_instr = e_rvc ? {16'h0, e0} : {half_at(model_pc + 32'd2), e0};
            check_eq("instr", instr, e_instr);
            check_eq("instr_pc", instr_pc, model_pc);
            check_eq("instr_rvc", {31'h0, instr_rvc}, {31'h0, e_rvc});
            $display("instr pc=%h instr=%h rvc=%0d", instr_pc, instr, instr_rvc);
            last_instr = instr;
            last_pc    = instr_pc;
            last_rvc   = instr_rvc;
            model_pc   = model_pc + (e_rvc ? 32'd2 : 32'd4);
            consumed++;
        end
        if (do_redir) model_pc = {rpc[31:1], 1'b0};
        pending   = fetch_valid && !fetch_ready;
        prev_addr = fetch_addr;
    endtask

    task automatic run_until(input string tag, input int target, input int budget,
                             input int rdy, input int irdy);
        int n;
        n = 0;
        while (consumed < target && n < budget) begin
            step(rdy, irdy, 1'b0, 32'h0);
            n++;
        end
        check_eq(tag, (consumed >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_fetch(input string tag);
        int n;
        n = 0;
        obs_fvalid = 1'b0;
        while (!obs_fvalid && n < 20) begin
            step(M_ZERO, M_ONE, 1'b0, 32'h0);
            n++;
        end
        check_eq(tag, {31'h0, obs_fvalid}, 32'h1);
    endtask

    task automatic reset_assert();
        @(negedge clock);
        reset       = 1'b1;
        fetch_ready = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        #1;
        check_eq("rst_fetch_valid", {31'h0, fetch_valid}, 32'h1);
        check_eq("rst_fetch_addr", fetch_addr, RESET_PC);
        check_eq("rst_instr_pc", instr_pc, RESET_PC);
        check_eq("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_instr_rvc", {31'h0, instr_rvc}, 32'h0);
        pending = 1'b0;
    endtask

    task automatic reset_release();
        @(negedge clock);
        reset    = 1'b0;
        model_pc = RESET_PC;
    endtask

    initial begin
        int base;
        logic [31:0] held;

        // Reset; word 0 holds two copies of halfword 0x0013.
        reset_assert();
        fill_random(1'b0);
        mem[0] = 32'h0013_0013;
        reset_release();
        base = consumed;
        run_until("first_instr_progress", base + 1, 30, M_ONE, M_ONE);
        check_eq("w0013_instr", last_instr, 32'h0013_0013);
        check_eq("w0013_pc", last_pc, 32'h0);
        check_eq("w0013_rvc", {31'h0, last_rvc}, 32'h0);

        // Compressed instruction followed by a word-straddling 32-bit one.
        reset_assert();
        fill_random(1'b0);
        mem[0] = 32'h0513_4501;
        mem[1] = 32'h0000_0085;
        reset_release();
        base = consumed;
        run_until("cli_progress", base + 1, 30, M_RAND, M_ONE);
        check_eq("cli_instr", last_instr, 32'h0000_4501);
        check_eq("cli_rvc", {31'h0, last_rvc}, 32'h1);
        run_until("straddle_progress", base + 2, 30, M_RAND, M_ONE);
        check_eq("straddle_instr", last_instr, 32'h0085_0513);
        check_eq("straddle_pc", last_pc, 32'h2);
        check_eq("straddle_rvc", {31'h0, last_rvc}, 32'h0);

        // Random mixed stream with random handshakes.
        fill_random(1'b0);
        reset_assert();
        reset_release();
        base = consumed;
        run_until("random_progress", base + 60, 600, M_RAND, M_RAND);

        // Redirect to an odd halfword: word fetch, low half dropped.
        step(M_ONE, M_ZERO, 1'b1, 32'h0000_0102);
        step(M_ZERO, M_ZERO, 1'b0, 32'h0);
        check_eq("redir_fetch_addr", obs_addr, 32'h0000_0100);
        check_eq("redir_fetch_valid", {31'h0, obs_fvalid}, 32'h1);
        base = consumed;
        run_until("redir_progress", base + 1, 50, M_RAND, M_ONE);
        check_eq("redir_first_pc", last_pc, 32'h0000_0102);

        // Redirect while the request is stalled: old address held, stale
        // response dropped, then the target is requested.
        wait_fetch("kill_reach_fetch");
        step(M_ZERO, M_ONE, 1'b1, 32'h0000_0240);
        held = obs_addr;
        for (int i = 0; i < 3; i++) begin
            step(M_ZERO, M_ONE, 1'b0, 32'h0);
            check_eq("kill_addr_stable", obs_addr, held);
            check_eq("kill_valid_stable", {31'h0, obs_fvalid}, 32'h1);
        end
        step(M_ONE, M_ONE, 1'b0, 32'h0);
        step(M_ZERO, M_ONE, 1'b0, 32'h0);
        check_eq("kill_next_addr", obs_addr, 32'h0000_0240);
        base = consumed;
        run_until("kill_progress", base + 1, 50, M_RAND, M_ONE);
        check_eq("kill_first_pc", last_pc, 32'h0000_0240);

        // Back-pressure with a 16-bit stream: queue fills, fetching stops,
        // and the stream resumes in order.
        reset_assert();
        fill_random(1'b1);
        reset_release();
        for (int i = 0; i < 10; i++) step(M_ONE, M_ZERO, 1'b0, 32'h0);
        check_eq("stall_fetch_off", {31'h0, obs_fvalid}, 32'h0);
        check_eq("stall_instr_valid", {31'h0, instr_valid}, 32'h1);
        base = consumed;
        run_until("stall_resume", base + 40, 400, M_RAND, M_RAND);
        check_eq("stall_order_pc", last_pc, RESET_PC + 32'd78);

        // Address wrap past the top of the 32-bit space.
        fill_random(1'b0);
        reset_assert();
        reset_release();
        step(M_ONE, M_ZERO, 1'b1, 32'hFFFF_FFFC);
        base = consumed;
        run_until("wrap_first", base + 1, 50, M_RAND, M_ONE);
        check_eq("wrap_first_pc", last_pc, 32'hFFFF_FFFC);
        run_until("wrap_progress", base + 6, 100, M_RAND, M_RAND);

        // Reset in the middle of an outstanding request.
        wait_fetch("rst_reach_fetch");
        reset_assert();
        reset_release();
        step(M_ZERO, M_ZERO, 1'b0, 32'h0);
        check_eq("rst_refetch_addr", obs_addr, RESET_PC);
        check_eq("rst_refetch_valid", {31'h0, obs_fvalid}, 32'h1);
        base = consumed;
        run_until("rst_refetch_progress", base + 1, 50, M_RAND, M_ONE);
        check_eq("rst_refetch_pc", last_pc, RESET_PC);

        // Random redirects mixed into random traffic.
        base = consumed;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 4) begin
                step(M_RAND, M_RAND, 1'b1, $urandom);
            end else begin
                step(M_RAND, M_RAND, 1'b0, 32'h0);
            end
        end
        check_eq("redir_mix_progress", (consumed > base + 50) ? 32'd1 : 32'd0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
